// File: rtl/divider_pkg.sv
// Shared types and default widths for the iterative restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DW_DEF);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   partial_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   partial_o,
    output logic          qbit_o
);

    logic [VW:0] shifted;
    logic [VW:0] trial;
    logic        unused_msb;

    // The partial remainder stays below the divisor, so its top bit is always 0.
    assign unused_msb = partial_i[VW];
    assign shifted    = {partial_i[VW-1:0], bit_i};
    assign trial      = shifted - {1'b0, divisor_i};
    assign qbit_o     = ~trial[VW];
    assign partial_o  = qbit_o ? trial : shifted;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider with valid/ready handshakes on both sides.
module seq_divider
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = cnt_w(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_t    state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] rem_q;
    logic          dbz_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] shift_q;
    logic [VW:0]   part_q;
    logic [VW-1:0] dvsr_q;

    logic [VW:0]   part_d;
    logic          qbit;
    logic [DW-1:0] shift_d;

    div_step #(.VW(VW)) u_step (
        .partial_i (part_q),
        .bit_i     (shift_q[DW-1]),
        .divisor_i (dvsr_q),
        .partial_o (part_d),
        .qbit_o    (qbit)
    );

    // Dividend bits leave at the MSB while quotient bits fill from the LSB.
    assign shift_d = {shift_q[DW-2:0], qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            part_q      <= '0;
            dvsr_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        shift_q    <= dividend;
                        dvsr_q     <= divisor;
                        part_q     <= '0;
                        cnt_q      <= '0;
                        dbz_q      <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= '1;
                            rem_q       <= '0;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    part_q  <= part_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quot_q      <= shift_d;
                        rem_q       <= part_d[VW-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
